// File: rtl/m68k_bus_arbiter.sv
// 68000 bus mastership arbiter: shares the bus between the local transaction
// engine and external BR/BG/BGACK masters, clocked in the 200 MHz Pi domain.
module m68k_bus_arbiter #(
  parameter int SYNC_STAGES    = 2,
  parameter int BR_FILTER      = 2,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic       c200m,
  input  logic       reset,
  input  logic       c7m_rising,
  input  logic       c7m_falling,
  input  logic       op_req,
  input  logic       op_busy,
  input  logic       bus_as_n,
  input  logic       M68K_BR_n,
  input  logic       M68K_BGACK_n,
  output logic       M68K_BG_n,
  output logic       op_grant,
  output logic       drive_en,
  output logic       ext_owner,
  output logic [2:0] arb_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOCAL    = 3'd1,
    GRANT    = 3'd2,
    EXTERNAL = 3'd3,
    RECOVER  = 3'd4
  } state_e;

  localparam logic [2:0] BR_LIM   = 3'(BR_FILTER);
  localparam logic [3:0] REC_LAST = 4'(RECOVER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] br_sync_q;
  logic [SYNC_STAGES-1:0] bgack_sync_q;
  logic                   br_s;
  logic                   bgack_s;
  logic [2:0]             br_cnt_q;
  logic                   br_req_q;
  state_e                 state_q;
  logic                   bg_n_q;
  logic                   op_grant_q;
  logic                   drive_en_q;
  logic                   ext_owner_q;
  logic                   fair_local_q;
  logic                   seen_busy_q;
  logic [3:0]             rec_cnt_q;
  logic                   unused_c7m_falling;

  assign unused_c7m_falling = c7m_falling;

  // Bring the asynchronous bus request/acknowledge into the c200m domain.
  always_ff @(posedge c200m or posedge reset) begin
    if (reset) begin
      br_sync_q    <= '1;
      bgack_sync_q <= '1;
    end else begin
      br_sync_q    <= {br_sync_q[SYNC_STAGES-2:0], M68K_BR_n};
      bgack_sync_q <= {bgack_sync_q[SYNC_STAGES-2:0], M68K_BGACK_n};
    end
  end

  assign br_s    = br_sync_q[SYNC_STAGES-1];
  assign bgack_s = bgack_sync_q[SYNC_STAGES-1];

  // BR must stay low for BR_FILTER consecutive 68K clock edges to count as a request.
  always_ff @(posedge c200m or posedge reset) begin
    if (reset) begin
      br_cnt_q <= 3'd0;
      br_req_q <= 1'b0;
    end else if (c7m_rising) begin
      if (br_s) begin
        br_cnt_q <= 3'd0;
        br_req_q <= 1'b0;
      end else begin
        if (br_cnt_q != BR_LIM) begin
          br_cnt_q <= br_cnt_q + 3'd1;
        end
        br_req_q <= (br_cnt_q >= (BR_LIM - 3'd1));
      end
    end
  end

  // Ownership FSM; outputs are registered together with the state they belong to.
  always_ff @(posedge c200m or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bg_n_q       <= 1'b1;
      op_grant_q   <= 1'b0;
      drive_en_q   <= 1'b1;
      ext_owner_q  <= 1'b0;
      fair_local_q <= 1'b0;
      seen_busy_q  <= 1'b0;
      rec_cnt_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bgack_s) begin
            state_q     <= EXTERNAL;
            drive_en_q  <= 1'b0;
            ext_owner_q <= 1'b1;
          end else if (br_req_q && bus_as_n && !(fair_local_q && op_req)) begin
            state_q <= GRANT;
            bg_n_q  <= 1'b0;
          end else if (op_req && c7m_rising) begin
            state_q      <= LOCAL;
            op_grant_q   <= 1'b1;
            seen_busy_q  <= 1'b0;
            fair_local_q <= 1'b0;
          end
        end
        LOCAL: begin
          if (op_busy) begin
            op_grant_q  <= 1'b0;
            seen_busy_q <= 1'b1;
          end else if (seen_busy_q) begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (!bgack_s) begin
            state_q     <= EXTERNAL;
            bg_n_q      <= 1'b1;
            drive_en_q  <= 1'b0;
            ext_owner_q <= 1'b1;
          end else if (br_s) begin
            state_q <= IDLE;
            bg_n_q  <= 1'b1;
          end
        end
        EXTERNAL: begin
          // A local op still pending at release is owed the next slot.
          if (bgack_s) begin
            state_q      <= RECOVER;
            drive_en_q   <= 1'b1;
            ext_owner_q  <= 1'b0;
            fair_local_q <= op_req;
            rec_cnt_q    <= 4'd0;
          end
        end
        RECOVER: begin
          if (!bgack_s) begin
            state_q     <= EXTERNAL;
            drive_en_q  <= 1'b0;
            ext_owner_q <= 1'b1;
          end else if (c7m_rising) begin
            if (rec_cnt_q == REC_LAST) begin
              state_q <= IDLE;
            end else begin
              rec_cnt_q <= rec_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          bg_n_q      <= 1'b1;
          op_grant_q  <= 1'b0;
          drive_en_q  <= 1'b1;
          ext_owner_q <= 1'b0;
        end
      endcase
    end
  end

  assign M68K_BG_n = bg_n_q;
  assign op_grant  = op_grant_q;
  assign drive_en  = drive_en_q;
  assign ext_owner = ext_owner_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Bench for m68k_bus_arbiter: directed scenarios with literal expectations, then
// randomized engine/external-master traffic checked every cycle against a model.
module tb_m68k_bus_arbiter;

  localparam int SYNC_STAGES    = 2;
  localparam int BR_FILTER      = 2;
  localparam int RECOVER_CYCLES = 2;
  localparam int C7M_PERIOD     = 6;

  logic       c200m = 1'b0;
  logic       reset;
  logic       c7m_rising;
  logic       c7m_falling;
  logic       op_req;
  logic       op_busy;
  logic       bus_as_n;
  logic       M68K_BR_n;
  logic       M68K_BGACK_n;
  logic       M68K_BG_n;
  logic       op_grant;
  logic       drive_en;
  logic       ext_owner;
  logic [2:0] arb_state;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  m68k_bus_arbiter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .BR_FILTER     (BR_FILTER),
    .RECOVER_CYCLES(RECOVER_CYCLES)
  ) dut (
    .c200m       (c200m),
    .reset       (reset),
    .c7m_rising  (c7m_rising),
    .c7m_falling (c7m_falling),
    .op_req      (op_req),
    .op_busy     (op_busy),
    .bus_as_n    (bus_as_n),
    .M68K_BR_n   (M68K_BR_n),
    .M68K_BGACK_n(M68K_BGACK_n),
    .M68K_BG_n   (M68K_BG_n),
    .op_grant    (op_grant),
    .drive_en    (drive_en),
    .ext_owner   (ext_owner),
    .arb_state   (arb_state)
  );

  always #5 c200m = ~c200m;

  // 68K clock edge strobes, updated just after each falling c200m edge.
  initial begin
    int ph;
    ph = 0;
    c7m_rising  = 1'b0;
    c7m_falling = 1'b0;
    forever begin
      @(negedge c200m);
      #1;
      ph = (ph + 1) % C7M_PERIOD;
      c7m_rising  = (ph == 0);
      c7m_falling = (ph == C7M_PERIOD / 2);
    end
  end

  // Reference model: owner mode 0 idle, 1 local, 2 granted, 3 external, 4 recovering.
  int m_mode, m_rec, m_low, since_rst;
  bit m_fair, m_seen, m_req;
  bit br_raw[$];
  bit bgk_raw[$];

  always @(posedge c200m or posedge reset) begin : ref_model
    bit br_s, bgk_s;
    int sz, low_n;
    if (reset) begin
      m_mode    <= 0;
      m_fair    <= 1'b0;
      m_seen    <= 1'b0;
      m_rec     <= 0;
      m_low     <= 0;
      m_req     <= 1'b0;
      since_rst <= 0;
    end else begin
      sz    = br_raw.size();
      br_s  = (since_rst >= SYNC_STAGES) ? br_raw[sz - SYNC_STAGES]  : 1'b1;
      bgk_s = (since_rst >= SYNC_STAGES) ? bgk_raw[sz - SYNC_STAGES] : 1'b1;
      br_raw.push_back(M68K_BR_n);
      bgk_raw.push_back(M68K_BGACK_n);
      since_rst <= since_rst + 1;
      case (m_mode)
        0: begin
          if (!bgk_s) m_mode <= 3;
          else if (m_req && bus_as_n && !(m_fair && op_req)) m_mode <= 2;
          else if (op_req && c7m_rising) begin
            m_mode <= 1;
            m_seen <= 1'b0;
            m_fair <= 1'b0;
          end
        end
        1: begin
          if (op_busy) m_seen <= 1'b1;
          else if (m_seen) m_mode <= 0;
        end
        2: begin
          if (!bgk_s) m_mode <= 3;
          else if (br_s) m_mode <= 0;
        end
        3: begin
          if (bgk_s) begin
            m_mode <= 4;
            m_fair <= op_req;
            m_rec  <= 0;
          end
        end
        4: begin
          if (!bgk_s) m_mode <= 3;
          else if (c7m_rising) begin
            if (m_rec + 1 >= RECOVER_CYCLES) m_mode <= 0;
            else m_rec <= m_rec + 1;
          end
        end
        default: m_mode <= 0;
      endcase
      if (c7m_rising) begin
        low_n = br_s ? 0 : m_low + 1;
        m_low <= low_n;
        m_req <= (low_n >= BR_FILTER);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge c200m) begin
    if (chk_en) begin
      logic e_bg, e_grant, e_drive, e_ext;
      e_bg    = (m_mode != 2);
      e_grant = (m_mode == 1) && !m_seen;
      e_drive = (m_mode != 3);
      e_ext   = (m_mode == 3);
      vectors++;
      if ({M68K_BG_n, op_grant, drive_en, ext_owner, arb_state} !==
          {e_bg, e_grant, e_drive, e_ext, 3'(m_mode)}) begin
        miscompares++;
        $display("FAIL model t=%0t: bg_n/grant/drive/ext/state got %b%b%b%b/%0d, required %b%b%b%b/%0d",
                 $time, M68K_BG_n, op_grant, drive_en, ext_owner, arb_state,
                 e_bg, e_grant, e_drive, e_ext, m_mode);
      end
    end
  end

  task automatic cyc();
    @(negedge c200m);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input string nm, input int limit, input int st);
    int k;
    k = 0;
    while (int'(arb_state) != st && k < limit) begin
      cyc();
      k++;
    end
    chk(nm, int'(arb_state), st);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nstrobe, eng_phase, eng_cnt, ms_phase, ms_cnt, rst_cnt;
    bit saw;
    reset        = 1'b1;
    op_req       = 1'b0;
    op_busy      = 1'b0;
    bus_as_n     = 1'b1;
    M68K_BR_n    = 1'b1;
    M68K_BGACK_n = 1'b1;
    repeat (3) cyc();
    chk_en = 1'b1;
    chk("rst_bg_n", M68K_BG_n, 1);
    chk("rst_op_grant", op_grant, 0);
    chk("rst_drive_en", drive_en, 1);
    chk("rst_ext_owner", ext_owner, 0);
    chk("rst_state", arb_state, 0);
    reset = 1'b0;
    cyc();

    // Local transaction.
    op_req = 1'b1;
    wait_state("local_entry", C7M_PERIOD + 2, 1);
    chk("local_grant", op_grant, 1);
    op_busy = 1'b1; bus_as_n = 1'b0;
    cyc();
    chk("local_grant_drop", op_grant, 0);
    chk("local_hold", arb_state, 1);
    cyc();
    op_busy = 1'b0; bus_as_n = 1'b1; op_req = 1'b0;
    cyc();
    chk("local_exit", arb_state, 0);

    // Reset during a busy local transaction.
    op_req = 1'b1;
    wait_state("local_again", C7M_PERIOD + 2, 1);
    op_busy = 1'b1;
    cyc();
    reset = 1'b1;
    #1;
    chk("midrst_state", arb_state, 0);
    chk("midrst_bg_n", M68K_BG_n, 1);
    chk("midrst_drive_en", drive_en, 1);
    chk("midrst_grant", op_grant, 0);
    cyc();
    reset = 1'b0; op_busy = 1'b0; op_req = 1'b0;
    cyc();

    // External request, grant, tenure and recovery.
    M68K_BR_n = 1'b0;
    wait_state("grant_entry", (SYNC_STAGES + BR_FILTER) * C7M_PERIOD, 2);
    chk("grant_bg_n", M68K_BG_n, 0);
    M68K_BGACK_n = 1'b0;
    wait_state("ext_entry", SYNC_STAGES + 2, 3);
    chk("ext_drive_en", drive_en, 0);
    chk("ext_owner", ext_owner, 1);
    chk("ext_bg_n", M68K_BG_n, 1);
    M68K_BR_n = 1'b1;
    repeat (20) cyc();
    M68K_BGACK_n = 1'b1;
    wait_state("recover_entry", SYNC_STAGES + 2, 4);
    chk("recover_drive_en", drive_en, 1);
    chk("recover_ext_owner", ext_owner, 0);
    nstrobe = 0; k = 0;
    while (arb_state == 3'd4 && k < 40) begin
      if (c7m_rising) nstrobe++;
      cyc();
      k++;
    end
    chk("recover_strobes", nstrobe, RECOVER_CYCLES);
    chk("recover_exit", arb_state, 0);

    // Request withdrawn while granted.
    M68K_BR_n = 1'b0;
    wait_state("grant_withdraw", (SYNC_STAGES + BR_FILTER) * C7M_PERIOD, 2);
    M68K_BR_n = 1'b1;
    saw = 1'b0;
    repeat (3 * C7M_PERIOD) begin
      cyc();
      if (arb_state == 3'd3) saw = 1'b1;
    end
    chk("withdraw_state", arb_state, 0);
    chk("withdraw_bg_n", M68K_BG_n, 1);
    chk("withdraw_no_ext", saw, 0);

    // Fairness: a local op pending across the tenure is served before BR.
    M68K_BR_n = 1'b0;
    wait_state("fair_grant", (SYNC_STAGES + BR_FILTER) * C7M_PERIOD, 2);
    op_req = 1'b1;
    M68K_BGACK_n = 1'b0;
    wait_state("fair_ext", SYNC_STAGES + 2, 3);
    repeat (20) cyc();
    M68K_BGACK_n = 1'b1;
    wait_state("fair_recover", SYNC_STAGES + 2, 4);
    k = 0;
    while ((arb_state == 3'd4 || arb_state == 3'd0) && k < 40) begin
      cyc();
      k++;
    end
    chk("fair_local_first", arb_state, 1);
    op_busy = 1'b1; bus_as_n = 1'b0;
    cyc(); cyc();
    op_busy = 1'b0; bus_as_n = 1'b1; op_req = 1'b0;
    wait_state("fair_then_grant", 4, 2);
    M68K_BR_n = 1'b1;
    wait_state("fair_release", 4, 0);
    repeat (3 * C7M_PERIOD) cyc();

    // Short BR pulse is filtered; BGACK alone seizes the bus.
    M68K_BR_n = 1'b0;
    repeat (C7M_PERIOD) cyc();
    M68K_BR_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      cyc();
      if (!M68K_BG_n) saw = 1'b1;
    end
    chk("short_br_no_grant", saw, 0);
    M68K_BGACK_n = 1'b0;
    wait_state("seize_ext", SYNC_STAGES + 2, 3);
    chk("seize_drive_en", drive_en, 0);
    M68K_BGACK_n = 1'b1;
    wait_state("seize_recover", SYNC_STAGES + 2, 4);
    wait_state("seize_idle", (RECOVER_CYCLES + 1) * C7M_PERIOD, 0);

    // Randomized engine and external-master traffic.
    eng_phase = 0; eng_cnt = 0; ms_phase = 0; ms_cnt = 0; rst_cnt = 0;
    repeat (20000) begin
      cyc();
      if (rst_cnt > 0) begin
        rst_cnt--;
        reset = (rst_cnt != 0);
      end else if ($urandom_range(0, 4999) == 0) begin
        reset = 1'b1;
        rst_cnt = 3;
      end
      case (eng_phase)
        0: if ($urandom_range(0, 15) == 0) begin op_req = 1'b1; eng_phase = 1; end
        1: if (op_grant) begin eng_cnt = $urandom_range(0, 3); eng_phase = 2; end
        2: if (eng_cnt == 0) begin op_busy = 1'b1; eng_cnt = $urandom_range(1, 6); eng_phase = 3; end
           else eng_cnt--;
        3: if (eng_cnt == 0) begin op_busy = 1'b0; op_req = 1'b0; eng_phase = 0; end
           else eng_cnt--;
        default: eng_phase = 0;
      endcase
      bus_as_n = op_busy ? 1'b0 : ($urandom_range(0, 9) != 0);
      case (ms_phase)
        0: begin
          k = $urandom_range(0, 99);
          if (k < 3) begin
            M68K_BR_n = 1'b0; ms_phase = 1;
          end else if (k == 3 && $urandom_range(0, 3) == 0) begin
            M68K_BGACK_n = 1'b0; ms_cnt = $urandom_range(3, 30); ms_phase = 3;
          end
        end
        1: begin
          if (!M68K_BG_n) begin
            ms_cnt = $urandom_range(0, 4); ms_phase = 2;
          end else if ($urandom_range(0, 299) == 0) begin
            M68K_BR_n = 1'b1; ms_phase = 0;
          end
        end
        2: begin
          if (ms_cnt == 0) begin
            M68K_BGACK_n = 1'b0;
            if ($urandom_range(0, 3) != 0) M68K_BR_n = 1'b1;
            ms_cnt = $urandom_range(5, 40);
            ms_phase = 3;
          end else ms_cnt--;
        end
        3: begin
          if (ms_cnt == 0) begin
            M68K_BGACK_n = 1'b1;
            ms_phase = M68K_BR_n ? 0 : 1;
          end else ms_cnt--;
        end
        default: ms_phase = 0;
      endcase
    end
    reset = 1'b0;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
